// File: rtl/conv_pe_sequencer_if.sv
// Handshake bundle between the ifmap source, the sequencer and the psum/ofmap writer.
interface conv_pe_sequencer_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   infmap_value;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] outpsum;

   modport master (
      output in_valid, infmap_value, out_ready,
      input  in_ready, out_valid, outpsum
   );

   modport slave (
      input  in_valid, infmap_value, out_ready,
      output in_ready, out_valid, outpsum
   );
endinterface

// File: rtl/conv_pe_sequencer.sv
// Sliding-window convolution sequencer: one PE MAC per cycle over a K-tap kernel of
// 2-bit signed weights, one ofmap psum per accepted ifmap value once the window is full.
module conv_pe_sequencer #(
   parameter int CONVOLUTION_DATA_WIDTH = 8,
   parameter int KERNEL_SIZE            = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      weight_load,
   input  logic [2*KERNEL_SIZE-1:0]  weight_in,
   output logic                      busy,
   conv_pe_sequencer_if.slave        bus
);
   localparam int W  = CONVOLUTION_DATA_WIDTH;
   localparam int K  = KERNEL_SIZE;
   localparam int TW = $clog2(K);
   localparam int FW = $clog2(K + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_e;

   state_e              state_q, state_d;
   logic [K-1:0][1:0]   w_q, w_d;
   logic [K-1:0][1:0]   win_q, win_d;
   logic [FW-1:0]       fill_q, fill_d;
   logic [TW-1:0]       tap_q, tap_d;
   logic [W-1:0]        acc_q, acc_d;

   logic signed [3:0]   w_ext, x_ext, prod;
   logic signed [W-1:0] prod_ext;

   // Products lie in [-2,4], so a 4-bit signed product is exact before widening to W.
   assign w_ext    = {{2{w_q[tap_q][1]}}, w_q[tap_q]};
   assign x_ext    = {{2{win_q[tap_q][1]}}, win_q[tap_q]};
   assign prod     = w_ext * x_ext;
   assign prod_ext = W'(prod);

   assign bus.outpsum = acc_q;
   assign busy        = (state_q != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         w_q     <= '0;
         win_q   <= '0;
         fill_q  <= '0;
         tap_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         win_q   <= win_d;
         fill_q  <= fill_d;
         tap_q   <= tap_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      w_d           = w_q;
      win_d         = win_q;
      fill_d        = fill_q;
      tap_d         = tap_q;
      acc_d         = acc_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A weight load wins over a same-cycle ifmap value, which is refused.
            bus.in_ready = !weight_load;
            if (weight_load) begin
               w_d    = weight_in;
               win_d  = '0;
               fill_d = '0;
            end else if (bus.in_valid) begin
               win_d  = {bus.infmap_value, win_q[K-1:1]};
               fill_d = (fill_q == FW'(K)) ? fill_q : fill_q + FW'(1);
               if (fill_d == FW'(K)) begin
                  acc_d   = '0;
                  tap_d   = '0;
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            acc_d = acc_q + prod_ext;
            tap_d = tap_q + TW'(1);
            if (tap_q == TW'(K - 1)) state_d = OUTPUT;
         end
         OUTPUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Directed bench: expected psums are queued at issue time and a monitor per DUT pops
// and compares whenever an output handshake occurs.
module tb_conv_pe_sequencer;
   localparam int K = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           wl8, wl4, busy8, busy4;
   logic [2*K-1:0] wi8, wi4;
   int             cyc = 0, n_vec = 0, n_mis = 0, acc_cyc = 0;
   int             q8[$];
   int             q4[$];

   conv_pe_sequencer_if #(.W(8)) b8();
   conv_pe_sequencer_if #(.W(4)) b4();

   conv_pe_sequencer #(.CONVOLUTION_DATA_WIDTH(8), .KERNEL_SIZE(K)) dut8 (
      .clk(clk), .reset(rst), .weight_load(wl8), .weight_in(wi8), .busy(busy8), .bus(b8.slave));
   conv_pe_sequencer #(.CONVOLUTION_DATA_WIDTH(4), .KERNEL_SIZE(K)) dut4 (
      .clk(clk), .reset(rst), .weight_load(wl4), .weight_in(wi4), .busy(busy4), .bus(b4.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm, input string why);
      n_vec++;
      n_mis++;
      $display("FAIL %s: %s", nm, why);
   endtask

   always @(negedge clk) begin
      if (!rst && b8.out_valid && b8.out_ready) begin
         if (q8.size() == 0)
            fail_now("out8_unexpected", $sformatf("got psum %0d, required no output", $signed(b8.outpsum)));
         else
            chk("out8", int'($signed(b8.outpsum)), q8.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!rst && b4.out_valid && b4.out_ready) begin
         if (q4.size() == 0)
            fail_now("out4_unexpected", $sformatf("got psum %0d, required no output", $signed(b4.outpsum)));
         else
            chk("out4", int'($signed(b4.outpsum)), q4.pop_front());
      end
   end

   task automatic load(input bit d4, input logic [2*K-1:0] w);
      if (d4) begin wl4 = 1'b1; wi4 = w; end
      else    begin wl8 = 1'b1; wi8 = w; end
      @(posedge clk); #1;
      wl4 = 1'b0;
      wl8 = 1'b0;
   endtask

   task automatic send(input bit d4, input logic [1:0] v);
      int t = 0;
      if (d4) begin b4.in_valid = 1'b1; b4.infmap_value = v; end
      else    begin b8.in_valid = 1'b1; b8.infmap_value = v; end
      @(negedge clk);
      while ((d4 ? b4.in_ready : b8.in_ready) !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) fail_now("send_timeout", "in_ready stayed low for 50 cycles, required high");
      acc_cyc = cyc;
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
      b8.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input bit d4);
      int t = 0;
      @(negedge clk);
      while ((d4 ? b4.out_valid : b8.out_valid) !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) fail_now("valid_timeout", "out_valid stayed low for 50 cycles, required high");
   endtask

   task automatic wait_idle(input bit d4);
      int t = 0;
      @(negedge clk);
      while ((d4 ? busy4 : busy8) !== 1'b0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) fail_now("idle_timeout", "busy stayed high for 50 cycles, required low");
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      b8.in_valid = 1'b0; b8.infmap_value = 2'b00; b8.out_ready = 1'b1;
      b4.in_valid = 1'b0; b4.infmap_value = 2'b00; b4.out_ready = 1'b1;
      wl8 = 1'b0; wl4 = 1'b0; wi8 = '0; wi4 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_in_ready", int'(b8.in_ready), 1);
      chk("rst_out_valid", int'(b8.out_valid), 0);
      chk("rst_busy", int'(busy8), 0);
      chk("rst_outpsum", int'($signed(b8.outpsum)), 0);
      chk("rst_outpsum4", int'($signed(b4.outpsum)), 0);
      @(posedge clk); #1;

      // w = (1,-1,1); first output only after the third value, K+1 cycles later
      load(1'b0, 6'b01_11_01);
      send(1'b0, 2'b01);
      send(1'b0, 2'b01);
      q8.push_back(1);
      send(1'b0, 2'b01);
      wait_valid(1'b0);
      chk("latency", cyc - acc_cyc, K + 1);

      // window (1,1,-2) -> -2, then (1,-2,1) -> 4
      q8.push_back(-2);
      send(1'b0, 2'b10);
      q8.push_back(4);
      send(1'b0, 2'b01);
      wait_idle(1'b0);

      // backpressure: window (-2,1,1) -> -2 held for 5 cycles
      b8.out_ready = 1'b0;
      q8.push_back(-2);
      send(1'b0, 2'b01);
      wait_valid(1'b0);
      repeat (5) begin
         chk("hold_outpsum", int'($signed(b8.outpsum)), -2);
         chk("hold_out_valid", int'(b8.out_valid), 1);
         chk("hold_in_ready", int'(b8.in_ready), 0);
         chk("hold_busy", int'(busy8), 1);
         @(negedge clk);
      end
      @(posedge clk); #1;
      b8.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_busy", int'(busy8), 0);
      chk("release_out_valid", int'(b8.out_valid), 0);
      @(posedge clk); #1;

      // weight_load during ACCUM is ignored: window (1,1,1) with old weights -> 1
      q8.push_back(1);
      send(1'b0, 2'b01);
      load(1'b0, 6'b10_10_10);
      wait_idle(1'b0);

      // weight_load with in_valid in IDLE: value refused, window flushed
      wl8 = 1'b1; wi8 = 6'b01_01_01;
      b8.in_valid = 1'b1; b8.infmap_value = 2'b10;
      @(negedge clk);
      chk("wl_in_ready", int'(b8.in_ready), 0);
      @(posedge clk); #1;
      wl8 = 1'b0;
      b8.in_valid = 1'b0;
      send(1'b0, 2'b01);
      send(1'b0, 2'b01);
      q8.push_back(3);
      send(1'b0, 2'b01);
      wait_idle(1'b0);

      // reset mid-ACCUM drops the pending output and clears weights/window
      send(1'b0, 2'b01);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", int'(b8.out_valid), 0);
      chk("abort_busy", int'(busy8), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      send(1'b0, 2'b01);
      send(1'b0, 2'b01);
      q8.push_back(0);
      send(1'b0, 2'b01);
      wait_idle(1'b0);

      // W=4: w=(-2,-2,-2), inputs -2 x3 -> 12 wraps to -4
      load(1'b1, 6'b10_10_10);
      send(1'b1, 2'b10);
      send(1'b1, 2'b10);
      q4.push_back(-4);
      send(1'b1, 2'b10);
      wait_idle(1'b1);

      repeat (4) @(posedge clk);
      chk("q8_drained", q8.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
